instr_fetch_stage: RTL

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/instr_fetch_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: sequential PC generation, single outstanding memory read,
// 2-entry {I,PC} buffer toward the branch datapath, redirect/flush and misalign halt.
module instr_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    input  logic        ready,
    output logic [31:0] I,
    output logic [63:0] PC,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        misalign_err
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [63:0] fetch_pc_r;
    logic        inflight_r;
    logic [63:0] inflight_pc_r;
    logic [1:0]  count_r;
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [31:0] fifo_i_r  [2];
    logic [63:0] fifo_pc_r [2];
    logic        misalign_err_r;

    logic        pop_s;
    logic        push_s;
    logic        redirect_s;
    logic        aligned_s;
    logic [2:0]  occupancy_s;

    // Handshake, occupancy look-ahead and head-of-buffer outputs
    always_comb begin
        valid       = (count_r != 2'd0);
        pop_s       = valid && ready;
        redirect_s  = (state_r == ST_RUN) && branch_taken;
        aligned_s   = (branch_target[1:0] == 2'b00);
        push_s      = inflight_r && !redirect_s;
        // Entries that will exist after this edge if no new request is issued
        occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        imem_req    = (state_r == ST_RUN) && !branch_taken && (occupancy_s <= 3'd1);
        imem_addr   = fetch_pc_r;
        misalign_err = misalign_err_r;
        if (valid) begin
            I  = fifo_i_r[rd_ptr_r];
            PC = fifo_pc_r[rd_ptr_r];
        end else begin
            I  = 32'h0;
            PC = 64'h0;
        end
    end

    // Next-state logic: a misaligned redirect is the only way into HALT
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_s && !aligned_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State register and sticky misalign flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_RUN;
            misalign_err_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            misalign_err_r <= misalign_err_r | (redirect_s && !aligned_s);
        end
    end

    // Fetch PC and the single outstanding request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 64'h0;
        end else if (redirect_s) begin
            inflight_r <= 1'b0;
            if (aligned_s) begin
                fetch_pc_r <= branch_target;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end else if (imem_req) begin
            fetch_pc_r    <= fetch_pc_r + 64'd4;
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    // Two-entry instruction buffer; a redirect discards everything not handed off this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r      <= 2'd0;
            rd_ptr_r     <= 1'b0;
            wr_ptr_r     <= 1'b0;
            fifo_i_r[0]  <= 32'h0;
            fifo_i_r[1]  <= 32'h0;
            fifo_pc_r[0] <= 64'h0;
            fifo_pc_r[1] <= 64'h0;
        end else if (redirect_s) begin
            count_r  <= 2'd0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_i_r[wr_ptr_r]  <= imem_rdata;
                fifo_pc_r[wr_ptr_r] <= inflight_pc_r;
                wr_ptr_r            <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
